// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer rectangle-fill engine.
package fb_pkg;

   localparam int FB_ADDR_W     = 27;
   localparam int FB_COLOR_W    = 12;
   localparam int FB_CRD_W      = 10;
   localparam int FB_END_W      = 11;
   localparam int FB_DEF_WIDTH  = 320;
   localparam int FB_DEF_HEIGHT = 240;

   typedef logic [FB_COLOR_W-1:0] fb_color_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } fb_rect_state_t;

endpackage

// File: rtl/fb_rect_clip.sv
// Rectangle extent and empty-command detection.
// Optional macro FB_RECT_CLIP_EN: clip extents to the screen and treat
// fully off-screen rectangles as empty. Without it the extents are
// unclipped and only zero-size rectangles are empty.
module fb_rect_clip
   import fb_pkg::*;
#(
   parameter int FB_WIDTH  = FB_DEF_WIDTH,
   parameter int FB_HEIGHT = FB_DEF_HEIGHT
) (
   input  logic [FB_CRD_W-1:0] i_x,
   input  logic [FB_CRD_W-1:0] i_y,
   input  logic [FB_CRD_W-1:0] i_w,
   input  logic [FB_CRD_W-1:0] i_h,
   output logic [FB_END_W-1:0] o_x_end,
   output logic [FB_END_W-1:0] o_y_end,
   output logic                o_empty
);

   logic [FB_END_W-1:0] w_x_sum;
   logic [FB_END_W-1:0] w_y_sum;

   assign w_x_sum = {1'b0, i_x} + {1'b0, i_w};
   assign w_y_sum = {1'b0, i_y} + {1'b0, i_h};

   // Exclusive end coordinates and empty flag.
   always_comb begin
`ifdef FB_RECT_CLIP_EN
      o_x_end = (w_x_sum > FB_END_W'(FB_WIDTH))  ? FB_END_W'(FB_WIDTH)  : w_x_sum;
      o_y_end = (w_y_sum > FB_END_W'(FB_HEIGHT)) ? FB_END_W'(FB_HEIGHT) : w_y_sum;
      o_empty = (i_w == '0) || (i_h == '0) ||
                ({1'b0, i_x} >= FB_END_W'(FB_WIDTH)) ||
                ({1'b0, i_y} >= FB_END_W'(FB_HEIGHT));
`else
      o_x_end = w_x_sum;
      o_y_end = w_y_sum;
      o_empty = (i_w == '0) || (i_h == '0);
`endif
   end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine: one 16-bit bridge write per pixel, row-major.
// Optional macro FB_RECT_CLIP_EN (see fb_rect_clip) enables screen clipping.
//
// state  | meaning
// IDLE   | ready for a command
// SETUP  | compute extents and first row address
// WRITE  | bridge write held until acknowledge, one pixel per ack
// DONE   | one-cycle completion pulse
module fb_rect_fill
   import fb_pkg::*;
#(
   parameter logic [FB_ADDR_W-1:0] FB_BASE   = 27'h0000000,
   parameter int                   FB_WIDTH  = FB_DEF_WIDTH,
   parameter int                   FB_HEIGHT = FB_DEF_HEIGHT
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [FB_CRD_W-1:0]  cmd_x,
   input  logic [FB_CRD_W-1:0]  cmd_y,
   input  logic [FB_CRD_W-1:0]  cmd_w,
   input  logic [FB_CRD_W-1:0]  cmd_h,
   input  fb_color_t            cmd_color,
   output logic                 busy,
   output logic                 done,
   output logic [FB_ADDR_W-1:0] bridge_memory_address,
   output logic [1:0]           bridge_memory_byte_enable,
   output logic                 bridge_memory_read,
   output logic                 bridge_memory_write,
   output logic [15:0]          bridge_memory_write_data,
   input  logic                 bridge_memory_acknowledge,
   input  logic [15:0]          bridge_memory_read_data
);

   fb_rect_state_t       r_state, w_state_nxt;
   logic [FB_CRD_W-1:0]  r_x, r_y, r_w, r_h;
   fb_color_t            r_color;
   logic [FB_END_W-1:0]  r_col, r_row;
   logic [FB_ADDR_W-1:0] r_row_addr, r_addr;

   logic [FB_END_W-1:0]  w_x_end, w_y_end, w_col_nxt, w_row_nxt;
   logic                 w_empty, w_col_last, w_row_last, w_ack;
   logic [FB_ADDR_W-1:0] w_pix_idx, w_setup_addr, w_next_row_addr;
   logic                 w_unused_rdata;

   assign w_unused_rdata = ^bridge_memory_read_data;

   fb_rect_clip #(
      .FB_WIDTH  (FB_WIDTH),
      .FB_HEIGHT (FB_HEIGHT)
   ) u_clip (
      .i_x     (r_x),
      .i_y     (r_y),
      .i_w     (r_w),
      .i_h     (r_h),
      .o_x_end (w_x_end),
      .o_y_end (w_y_end),
      .o_empty (w_empty)
   );

   assign w_pix_idx       = FB_ADDR_W'(r_y) * FB_ADDR_W'(FB_WIDTH) + FB_ADDR_W'(r_x);
   assign w_setup_addr    = FB_BASE + (w_pix_idx << 1);
   assign w_next_row_addr = r_row_addr + FB_ADDR_W'(2 * FB_WIDTH);
   assign w_col_nxt       = r_col + 1'b1;
   assign w_row_nxt       = r_row + 1'b1;
   assign w_col_last      = (w_col_nxt >= w_x_end);
   assign w_row_last      = (w_row_nxt >= w_y_end);
   assign w_ack           = (r_state == ST_WRITE) && bridge_memory_acknowledge;

   // State register; reset forces IDLE so a pending write drops at once.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) r_state <= ST_IDLE;
      else                r_state <= w_state_nxt;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (cmd_valid) w_state_nxt = ST_SETUP;
         ST_SETUP: w_state_nxt = w_empty ? ST_DONE : ST_WRITE;
         ST_WRITE: if (w_ack && w_col_last && w_row_last) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Command capture and pixel/address walk.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_x        <= '0;
         r_y        <= '0;
         r_w        <= '0;
         r_h        <= '0;
         r_color    <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_row_addr <= '0;
         r_addr     <= '0;
      end else begin
         if (r_state == ST_IDLE && cmd_valid) begin
            r_x     <= cmd_x;
            r_y     <= cmd_y;
            r_w     <= cmd_w;
            r_h     <= cmd_h;
            r_color <= cmd_color;
         end
         if (r_state == ST_SETUP) begin
            r_col      <= {1'b0, r_x};
            r_row      <= {1'b0, r_y};
            r_row_addr <= w_setup_addr;
            r_addr     <= w_setup_addr;
         end
         if (w_ack) begin
            if (!w_col_last) begin
               r_col  <= w_col_nxt;
               r_addr <= r_addr + FB_ADDR_W'(2);
            end else if (!w_row_last) begin
               r_col      <= {1'b0, r_x};
               r_row      <= w_row_nxt;
               r_row_addr <= w_next_row_addr;
               r_addr     <= w_next_row_addr;
            end
         end
      end
   end

   // Outputs decoded from state.
   always_comb begin
      cmd_ready                 = (r_state == ST_IDLE);
      busy                      = (r_state != ST_IDLE);
      done                      = (r_state == ST_DONE);
      bridge_memory_write       = (r_state == ST_WRITE);
      bridge_memory_byte_enable = (r_state == ST_WRITE) ? 2'b11 : 2'b00;
      bridge_memory_read        = 1'b0;
      bridge_memory_address     = r_addr;
      bridge_memory_write_data  = {4'h0, r_color};
   end

endmodule
